// File: rtl/edge_detect_pkg.sv
// Shared edge-detect mode encodings and helpers, also used by the UART RX start-bit logic.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // True when a level change in the given direction should raise an event under this mode.
  function automatic logic edge_enabled(input edge_mode_e mode, input logic rising);
    logic en;
    en = 1'b0;
    unique case (mode)
      MODE_OFF:  en = 1'b0;
      MODE_RISE: en = rising;
      MODE_FALL: en = ~rising;
      MODE_BOTH: en = 1'b1;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: synchronizer, persistence filter, mode-qualified edge strobe and sticky pending flag.
module edge_detect_chan #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       pending
);
  import edge_detect_pkg::*;

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   pending_q, pending_d;
  logic                   sync_s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    sync_s  = sync_q[SYNC_STAGES-1];
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    // Accept on the FILTER_LEN-th consecutive mismatch; the counter never passes CNT_LAST.
    if (sync_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_s;
        pulse_d = edge_enabled(edge_mode_e'(mode), sync_s);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pending_d = pulse_d | (pending_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{RESET_VAL}};
      cnt_q     <= '0;
      level_q   <= RESET_VAL;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign level   = level_q;
  assign pulse   = pulse_q;
  assign pending = pending_q;

endmodule

// File: rtl/edge_detect_multi.sv
// WIDTH independent filtered edge-detect channels with a combined pending flag.
module edge_detect_multi #(
  parameter int unsigned     WIDTH       = 4,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     FILTER_LEN  = 4,
  parameter logic [WIDTH-1:0] RESET_LEVEL = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sig_in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   pending,
  output logic               any_pending
);
  import edge_detect_pkg::*;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RESET_VAL   (RESET_LEVEL[g])
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_in  (sig_in[g]),
      .mode    (mode[2*g +: 2]),
      .clr     (clr[g]),
      .level   (level[g]),
      .pulse   (pulse[g]),
      .pending (pending[g])
    );
  end

  assign any_pending = |pending;

endmodule

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth per channel, minimum 2.
REQ-003 Parameter FILTER_LEN, default 4: consecutive cycles a new level must persist before acceptance, minimum 1 (1 = no filtering).
REQ-004 Parameter RESET_LEVEL, default {WIDTH{1'b1}}: per-channel idle level loaded at reset (UART idle high).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 sig_in  input  WIDTH  asynchronous raw inputs, one bit per channel.
REQ-008 mode  input  2*WIDTH  per-channel detect mode, bits [2i+1:2i] for channel i.
REQ-009 clr  input  WIDTH  per-channel write-1-to-clear for pending.
REQ-010 level  output  WIDTH  registered filtered level per channel.
REQ-011 pulse  output  WIDTH  registered one-cycle event strobe per channel.
REQ-012 pending  output  WIDTH  registered sticky event flag per channel.
REQ-013 any_pending  output  1  OR-reduction of pending.

Function
REQ-014 Mode encoding SHALL be 00 off, 01 rising, 10 falling, 11 both edges.
REQ-015 Each channel SHALL pass sig_in[i] through SYNC_STAGES flops before any other logic.
REQ-016 Filter: counter SHALL increment on each edge where synchronized value differs from level[i], SHALL clear to 0 on any edge where they match.
REQ-017 level[i] SHALL take the synchronized value on the edge where the mismatch has persisted FILTER_LEN consecutive edges; counter then clears.
REQ-018 Mismatch lasting fewer than FILTER_LEN consecutive synchronized cycles SHALL leave level, pulse, pending unchanged.
REQ-019 Counter width SHALL be clog2(FILTER_LEN+1); counter SHALL never wrap.
REQ-020 pulse[i] SHALL be high for exactly one cycle, updated on the same edge as level[i], when level[i] changes in a direction enabled by the current mode[i].
REQ-021 Latency: level and pulse SHALL update on rising edge number SHALL SYNC_STAGES+FILTER_LEN, counting the first edge sampling the new stable input as edge 1.
REQ-022 Mode changes SHALL never create an event; the mode value present on the edge where level changes SHALL decide pulse.
REQ-023 level SHALL track the filtered input regardless of mode (mode 00 suppresses pulse/pending only).
REQ-024 pending[i] SHALL set on the edge pulse[i] is asserted and hold until cleared by clr[i].
REQ-025 Simultaneous set and clr on the same channel: set SHALL win, pending stays 1.
REQ-026 Channels SHALL be fully independent; multiple channels may pulse in one cycle.

Reset
REQ-027 While rst_n low: all synchronizer flops and level SHALL equal RESET_LEVEL, counters 0, pulse 0, pending 0, any_pending 0.
REQ-028 Reset mid-filter SHALL discard the partial count; reset release SHALL generate no event when sig_in equals RESET_LEVEL.

Structure
REQ-029 Mode encodings (OFF, RISE, FALL, BOTH) SHALL live in shared package/header edge_detect_pkg, reused by UART RX start-bit logic.
REQ-030 Per-channel logic SHALL be sub-module edge_detect_chan, instantiated WIDTH times by generate; top adds only any_pending.

Verification
REQ-031 Defaults, ch0 mode 10, sig_in[0] 1->0 held -> level[0]=0 and pulse[0] one cycle on edge 6, pending[0]=1, any_pending=1.
REQ-032 ch1 mode 11, 3-cycle low glitch on sig_in[1] -> no pulse, level[1] stays 1; 4-cycle low glitch -> falling pulse then rising pulse.
REQ-033 ch2 mode 01, pending[2]=1, drive clr[2]=1 same cycle as new rising pulse -> pending[2] remains 1; clr[2] next cycle alone -> pending[2]=0.
REQ-034 Assert rst_n low mid-filter (count 2) on ch3 -> all outputs reset immediately; release with sig_in=1111 -> no pulse for 20 cycles.
REQ-035 ch0 mode 00, toggle input -> level follows, pulse/pending stay 0; switch mode to 11 with input stable -> no pulse.
REQ-036 Sweep WIDTH=1, FILTER_LEN=1, SYNC_STAGES=3 -> pulse latency exactly 4 edges on both directions.
